// File: rtl/data_mem_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pipe_if
//  Description : Memory request/response bus between the pipeline and the
//                data-memory stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_pipe_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          req_valid;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          done;
  logic          stall;
  logic          err;

  // Pipeline side: issues requests, observes completion and hold
  modport master (
    output req_valid, mem_read, mem_write, addr, wdata,
    input  rdata, done, stall, err
  );

  // Memory stage side
  modport slave (
    input  req_valid, mem_read, mem_write, addr, wdata,
    output rdata, done, stall, err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pipe
//  Description : Data-memory pipeline stage with fixed-latency word access,
//                next-PC branch select and halt/dump sequencing.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_pipe #(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,          // asynchronous, active-low
  data_mem_pipe_if.slave     bus,
  input  wire logic          halt,
  input  wire logic          branch,
  input  wire logic [1:0]    branch_op,
  input  wire logic          zero,
  input  wire logic          ltz,
  input  wire logic [AW-1:0] branch_addr,
  input  wire logic [AW-1:0] jump_addr,
  output logic      [AW-1:0] next_pc,
  output logic               dump
);

  localparam int             IW         = $clog2(DEPTH);
  localparam int             CW         = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam bit             C_SINGLE   = (LAT == 1);
  localparam logic [CW-1:0]  C_CNT_LOAD = CW'(LAT - 1);
  localparam logic [CW-1:0]  C_CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;

  logic          r_done, r_err, r_dump, r_dump_arm, r_halt_pend;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_idle, w_one_op, w_req_legal, w_req_illegal;
  logic          w_last, w_halt_seen, w_stall;
  logic          w_acc_fire, w_acc_wr;
  logic [IW-1:0] w_acc_idx;
  logic [DW-1:0] w_acc_wdata;
  logic          w_taken;

  // Address bits above the word index wrap modulo DEPTH and are not used
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^bus.addr[AW-1:IW+1];

  // Request classification; rst gating keeps a request from being taken
  // while reset is still asserted
  always_comb begin
    w_idle        = (r_state == S_IDLE) && rst;
    w_one_op      = bus.mem_read ^ bus.mem_write;
    w_req_legal   = w_idle && bus.req_valid && w_one_op && !bus.addr[0] && !halt;
    w_req_illegal = w_idle && bus.req_valid && !halt &&
                    ((bus.mem_read && bus.mem_write) || (w_one_op && bus.addr[0]));
    w_last        = (r_state == S_BUSY) && (r_cnt == C_CNT_ONE);
    w_halt_seen   = r_halt_pend || halt;
  end

  // FSM state and latency counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state / counter / stall; halt wins over a same-cycle request
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (halt) begin
          w_state_next = S_HALTED;
        end else if (w_req_legal) begin
          w_stall = 1'b1;
          if (!C_SINGLE) begin
            w_state_next = S_BUSY;
            w_cnt_next   = C_CNT_LOAD;
          end
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (w_last) begin
          w_state_next = w_halt_seen ? S_HALTED : S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt - C_CNT_ONE;
        end
      end
      S_HALTED: begin
        w_state_next = S_HALTED;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Access source: live inputs for single-cycle latency, else the request
  // captured at the end of the accept cycle
  generate
    if (C_SINGLE) begin : g_lat1
      assign w_acc_fire  = w_req_legal;
      assign w_acc_idx   = bus.addr[IW:1];
      assign w_acc_wr    = bus.mem_write;
      assign w_acc_wdata = bus.wdata;
    end else begin : g_latn
      logic [IW-1:0] r_idx;
      logic          r_wr;
      logic [DW-1:0] r_wdata;

      // Capture the accepted request; later input changes are ignored
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_idx   <= '0;
          r_wr    <= 1'b0;
          r_wdata <= '0;
        end else if (w_req_legal) begin
          r_idx   <= bus.addr[IW:1];
          r_wr    <= bus.mem_write;
          r_wdata <= bus.wdata;
        end
      end

      assign w_acc_fire  = w_last;
      assign w_acc_idx   = r_idx;
      assign w_acc_wr    = r_wr;
      assign w_acc_wdata = r_wdata;
    end
  endgenerate

  // Response pulses, load data and halt bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_dump      <= 1'b0;
      r_dump_arm  <= 1'b0;
      r_halt_pend <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_done      <= w_acc_fire;
      r_err       <= w_req_illegal;
      r_dump_arm  <= w_last && w_halt_seen;
      r_dump      <= (w_idle && halt) || r_dump_arm;
      r_halt_pend <= (r_state == S_BUSY) && !w_last && w_halt_seen;
      if (w_acc_fire && !w_acc_wr) begin
        r_rdata <= r_mem[w_acc_idx];
      end
    end
  end

  // Storage array; deliberately outside reset so contents survive it
  always_ff @(posedge clk) begin
    if (w_acc_fire && w_acc_wr) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  // Branch condition and next-PC select, independent of FSM state
  always_comb begin
    w_taken = 1'b0;
    case (branch_op)
      2'b00:   w_taken = zero;
      2'b01:   w_taken = !zero;
      2'b10:   w_taken = ltz;
      default: w_taken = !ltz;
    endcase
    w_taken = w_taken && branch;
    next_pc = w_taken ? branch_addr : jump_addr;
  end

  assign bus.rdata = r_rdata;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.stall = w_stall;
  assign dump      = r_dump;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_pipe
//  Description : Directed self-checking bench for data_mem_pipe (LAT=2,
//                DEPTH=256).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt, branch, zero, ltz;
  logic [1:0]  branch_op;
  logic [15:0] branch_addr, jump_addr, next_pc;
  logic        dump;

  int n_cmp = 0;
  int n_err = 0;

  data_mem_pipe_if #(.DW(16), .AW(16)) bus ();

  data_mem_pipe #(.DW(16), .AW(16), .DEPTH(256), .LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .halt        (halt),
    .branch      (branch),
    .branch_op   (branch_op),
    .zero        (zero),
    .ltz         (ltz),
    .branch_addr (branch_addr),
    .jump_addr   (jump_addr),
    .next_pc     (next_pc),
    .dump        (dump)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [15:0] d);
    bus.req_valid = v;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = d;
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    rst = 1'b0; halt = 1'b0; branch = 1'b0; branch_op = 2'b00;
    zero = 1'b0; ltz = 1'b0; branch_addr = 16'h0040; jump_addr = 16'h0100;
    idle();
    #3;
    chk("rst_done",  bus.done,  0);
    chk("rst_err",   bus.err,   0);
    chk("rst_dump",  dump,      0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_rdata", bus.rdata, 0);
    nxt(); nxt();
    rst = 1'b1;

    // Write 0xBEEF @0x0010, then back-to-back read in the done cycle
    req(1, 0, 1, 16'h0010, 16'hBEEF); #2;
    chk("wr_c0_stall", bus.stall, 1); chk("wr_c0_done", bus.done, 0);
    nxt(); req(0, 1, 0, 16'h0033, 16'h0000); #2;
    chk("wr_c1_stall", bus.stall, 1); chk("wr_c1_done", bus.done, 0);
    nxt(); req(1, 1, 0, 16'h0010, 16'h0000); #2;
    chk("wr_c2_done", bus.done, 1); chk("rd_c2_stall", bus.stall, 1);
    nxt(); idle(); #2;
    chk("rd_c3_stall", bus.stall, 1); chk("rd_c3_done", bus.done, 0);
    nxt(); #2;
    chk("rd_c4_done", bus.done, 1); chk("rd_c4_rdata", bus.rdata, 16'hBEEF);
    chk("rd_c4_stall", bus.stall, 0);
    nxt(); #2;
    chk("rd_c5_done", bus.done, 0); chk("rd_c5_hold", bus.rdata, 16'hBEEF);

    // Misaligned read
    req(1, 1, 0, 16'h0003, 16'h0000); #2;
    chk("mis_stall", bus.stall, 0);
    nxt(); idle(); #2;
    chk("mis_err", bus.err, 1); chk("mis_done", bus.done, 0); chk("mis_stall2", bus.stall, 0);
    nxt(); #2;
    chk("mis_err_clr", bus.err, 0);

    // Read and write together, then neither
    req(1, 1, 1, 16'h0010, 16'h1111); #2;
    chk("both_stall", bus.stall, 0);
    nxt(); req(1, 0, 0, 16'h0010, 16'h2222); #2;
    chk("both_err", bus.err, 1); chk("none_stall", bus.stall, 0);
    nxt(); idle(); #2;
    chk("none_err", bus.err, 0); chk("none_done", bus.done, 0);

    // Memory untouched by the rejected requests
    req(1, 1, 0, 16'h0010, 16'h0000);
    nxt(); idle(); nxt(); #2;
    chk("unch_done", bus.done, 1); chk("unch_rdata", bus.rdata, 16'hBEEF);

    // Next-PC select
    branch = 1'b1; branch_op = 2'b11; ltz = 1'b0; #1;
    chk("pc_ge_taken", next_pc, 16'h0040);
    ltz = 1'b1; #1;
    chk("pc_ge_not", next_pc, 16'h0100);
    branch_op = 2'b10; #1;
    chk("pc_lt_taken", next_pc, 16'h0040);
    branch_op = 2'b00; zero = 1'b1; #1;
    chk("pc_eq_taken", next_pc, 16'h0040);
    branch_op = 2'b01; #1;
    chk("pc_ne_not", next_pc, 16'h0100);
    branch = 1'b0; branch_op = 2'b00; #1;
    chk("pc_nobranch", next_pc, 16'h0100);

    // Address wrap: 0x0204 aliases 0x0004
    nxt();
    req(1, 0, 1, 16'h0004, 16'hAAAA);
    nxt(); idle();
    nxt(); req(1, 1, 0, 16'h0204, 16'h0000); #2;
    chk("wrap_wdone", bus.done, 1);
    nxt(); idle(); nxt(); #2;
    chk("wrap_done", bus.done, 1); chk("wrap_rdata", bus.rdata, 16'hAAAA);

    // Halt in IDLE beats a same-cycle request
    nxt();
    req(1, 1, 0, 16'h0010, 16'h0000); halt = 1'b1; #2;
    chk("hi_stall", bus.stall, 0);
    nxt(); halt = 1'b0; #2;
    chk("hi_dump", dump, 1); chk("hi_done", bus.done, 0); chk("hi_stall2", bus.stall, 0);
    nxt(); #2;
    chk("hi_dump_clr", dump, 0); chk("hi_ignored", bus.done, 0);

    // Reset out of HALTED
    idle(); rst = 1'b0; #2;
    nxt(); rst = 1'b1;

    // Reset during BUSY discards the pending write
    req(1, 0, 1, 16'h0020, 16'h5555);
    nxt(); idle();
    nxt(); req(1, 1, 0, 16'h0020, 16'h0000);
    nxt(); idle();
    nxt(); req(1, 0, 1, 16'h0020, 16'h9999); #2;
    chk("rb_done", bus.done, 1); chk("rb_rdata", bus.rdata, 16'h5555);
    nxt(); idle(); rst = 1'b0; #1;
    chk("rb_stall", bus.stall, 0); chk("rb_done0", bus.done, 0); chk("rb_rdata0", bus.rdata, 0);
    nxt(); nxt(); rst = 1'b1;
    req(1, 1, 0, 16'h0020, 16'h0000);
    nxt(); idle(); nxt(); #2;
    chk("rb_rd_done", bus.done, 1); chk("rb_rd_rdata", bus.rdata, 16'h5555);

    // Halt while BUSY: access completes, dump follows done
    nxt();
    req(1, 0, 1, 16'h0002, 16'h1234); #2;
    chk("hb_c0_stall", bus.stall, 1);
    nxt(); idle(); halt = 1'b1; #2;
    chk("hb_c1_stall", bus.stall, 1);
    nxt(); halt = 1'b0; #2;
    chk("hb_c2_done", bus.done, 1); chk("hb_c2_dump", dump, 0);
    nxt(); req(1, 1, 0, 16'h0002, 16'h0000); #2;
    chk("hb_c3_dump", dump, 1); chk("hb_c3_done", bus.done, 0); chk("hb_c3_stall", bus.stall, 0);
    nxt(); req(1, 1, 0, 16'h0003, 16'h0000); #2;
    chk("hb_c4_dump", dump, 0); chk("hb_c4_done", bus.done, 0); chk("hb_c4_stall", bus.stall, 0);
    nxt(); idle(); #2;
    chk("hb_c5_err", bus.err, 0); chk("hb_c5_done", bus.done, 0);
    branch = 1'b1; branch_op = 2'b00; zero = 1'b1; #1;
    chk("hb_pc_live", next_pc, 16'h0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
